// File: rtl/vga_scaled_scanout.sv
// vga_scaled_scanout: VGA scan-out engine with programmable timing, an
// integer-upscaled framebuffer window inside the visible area, a border
// fill around it and a delay line that keeps sync/blanking aligned with
// pixel data returned by a synchronous frame-buffer RAM.
//
// Pipeline: counter state (h_cnt, v_cnt) is decoded and registered into
// stage 0 together with read_addr/rd_en. The RAM answers RD_LATENCY cycles
// later, and the flags travel through the remaining delay-line stages
// so both arrive together, L = RD_LATENCY+1 cycles after the counter state.
// The colour mux after the last stage is purely combinational.
//
// Optional build macro VGA_TESTPAT_EN adds a test_mode input that replaces
// picture pixels with eight vertical colour bars and suppresses RAM reads.
module vga_scaled_scanout #(
    parameter int          H_ACTIVE     = 640,
    parameter int          H_FP         = 16,
    parameter int          H_SYNC       = 96,
    parameter int          H_BP         = 48,
    parameter int          V_ACTIVE     = 480,
    parameter int          V_FP         = 10,
    parameter int          V_SYNC       = 2,
    parameter int          V_BP         = 33,
    parameter int          HS_POL       = 0,
    parameter int          VS_POL       = 0,
    parameter int          FB_W         = 320,
    parameter int          FB_H         = 240,
    parameter int          SCALE        = 2,
    parameter int          RD_LATENCY   = 1,
    parameter int          ADDR_W       = 17,
    parameter logic [11:0] BORDER_COLOR = 12'h000
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef VGA_TESTPAT_EN
    input  logic              test_mode,
`endif
    input  logic [15:0]       pixel_data,
    output logic              rd_en,
    output logic [ADDR_W-1:0] read_addr,
    output logic              hsync,
    output logic              vsync,
    output logic [3:0]        red,
    output logic [3:0]        green,
    output logic [3:0]        blue,
    output logic              active_video,
    output logic              frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int L       = RD_LATENCY + 1;

    // Width-matched constants so every compare is between equal widths.
    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_PIC      = HW'(FB_W * SCALE);
    localparam logic [HW-1:0] H_PIC_LAST = HW'(FB_W * SCALE - 1);
    localparam logic [HW-1:0] H_SS       = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SE       = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_PIC      = VW'(FB_H * SCALE);
    localparam logic [VW-1:0] V_SS       = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SE       = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [1:0]    S_LAST     = 2'(SCALE - 1);
    localparam logic [ADDR_W-1:0] FB_W_A = ADDR_W'(FB_W);
    localparam logic [ADDR_W-1:0] ONE_A  = ADDR_W'(1);
    localparam logic          HS_ON      = 1'(HS_POL);
    localparam logic          VS_ON      = 1'(VS_POL);

    // Per-pixel flags carried down the delay line.
    typedef struct packed {
        logic act;
        logic pic;
        logic hs;
        logic vs;
        logic frm;
`ifdef VGA_TESTPAT_EN
        logic tm;
        logic [2:0] bar;
`endif
    } flags_t;

    logic [HW-1:0]     h_cnt;
    logic [VW-1:0]     v_cnt;
    logic [1:0]        sx;
    logic [1:0]        sy;
    logic [ADDR_W-1:0] x_addr;
    logic [ADDR_W-1:0] line_base;
    logic              h_wrap;
    logic              v_wrap;
    logic              in_pic_c;
    flags_t            cur;
    flags_t            dly [0:L-1];
    flags_t            o;
    logic              unused_pix;

    assign h_wrap   = (h_cnt == H_LAST);
    assign v_wrap   = (v_cnt == V_LAST);
    assign in_pic_c = (h_cnt < H_PIC) && (v_cnt < V_PIC);

    // Raster counters: h wraps every line, v steps on each h wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_wrap) begin
            h_cnt <= '0;
            v_cnt <= v_wrap ? '0 : v_cnt + VW'(1);
        end else begin
            h_cnt <= h_cnt + HW'(1);
        end
    end

    // Incremental address state: x_addr = h/SCALE, line_base = (v/SCALE)*FB_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sx        <= '0;
            sy        <= '0;
            x_addr    <= '0;
            line_base <= '0;
        end else if (h_wrap && v_wrap) begin
            sx        <= '0;
            sy        <= '0;
            x_addr    <= '0;
            line_base <= '0;
        end else if (in_pic_c) begin
            if (h_cnt == H_PIC_LAST) begin
                sx     <= '0;
                x_addr <= '0;
                if (sy == S_LAST) begin
                    sy        <= '0;
                    line_base <= line_base + FB_W_A;
                end else begin
                    sy <= sy + 2'd1;
                end
            end else if (sx == S_LAST) begin
                sx     <= '0;
                x_addr <= x_addr + ONE_A;
            end else begin
                sx <= sx + 2'd1;
            end
        end
    end

    // Registered read request for the current pixel; zero outside the picture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_addr <= '0;
            rd_en     <= 1'b0;
        end else if (in_pic_c) begin
            read_addr <= line_base + x_addr;
`ifdef VGA_TESTPAT_EN
            rd_en     <= ~test_mode;
`else
            rd_en     <= 1'b1;
`endif
        end else begin
            read_addr <= '0;
            rd_en     <= 1'b0;
        end
    end

`ifdef VGA_TESTPAT_EN
    localparam logic [HW-1:0] BAR_LAST = HW'(H_ACTIVE / 8 - 1);
    logic [HW-1:0] bar_px;
    logic [2:0]    bar_idx;

    // Colour-bar index across the visible line, restarted every line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bar_px  <= '0;
            bar_idx <= '0;
        end else if (h_wrap) begin
            bar_px  <= '0;
            bar_idx <= '0;
        end else if (h_cnt < H_ACT) begin
            if (bar_px == BAR_LAST) begin
                bar_px  <= '0;
                bar_idx <= bar_idx + 3'd1;
            end else begin
                bar_px <= bar_px + HW'(1);
            end
        end
    end

    // Bar order white..black as {R,G,B} on/off bits.
    function automatic logic [11:0] bar_rgb(input logic [2:0] idx);
        logic [2:0] on;
        case (idx)
            3'd0:    on = 3'b111;
            3'd1:    on = 3'b110;
            3'd2:    on = 3'b011;
            3'd3:    on = 3'b010;
            3'd4:    on = 3'b101;
            3'd5:    on = 3'b100;
            3'd6:    on = 3'b001;
            default: on = 3'b000;
        endcase
        return {{4{on[2]}}, {4{on[1]}}, {4{on[0]}}};
    endfunction
`endif

    // Decode the current counter state into the flags entering stage 0.
    always_comb begin
        cur     = '0;
        cur.act = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        cur.pic = in_pic_c;
        cur.hs  = (h_cnt >= H_SS) && (h_cnt < H_SE);
        cur.vs  = (v_cnt >= V_SS) && (v_cnt < V_SE);
        cur.frm = (h_cnt == '0) && (v_cnt == '0);
`ifdef VGA_TESTPAT_EN
        cur.tm  = test_mode;
        cur.bar = bar_idx;
`endif
    end

    // L-deep delay line: stage 0 is the decode register, the rest cover RAM latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < L; i++) dly[i] <= '0;
        end else begin
            dly[0] <= cur;
            for (int i = 1; i < L; i++) dly[i] <= dly[i-1];
        end
    end

    assign o            = dly[L-1];
    assign active_video = o.act;
    assign frame_start  = o.frm;
    assign hsync        = o.hs ? HS_ON : ~HS_ON;
    assign vsync        = o.vs ? VS_ON : ~VS_ON;
    assign unused_pix   = ^{pixel_data[11], pixel_data[6:5], pixel_data[0]};

    // Colour select: picture from RAM (or bars), border colour, or black in blanking.
    always_comb begin
        {red, green, blue} = 12'h000;
        if (o.act) begin
            if (o.pic) begin
`ifdef VGA_TESTPAT_EN
                if (o.tm) {red, green, blue} = bar_rgb(o.bar);
                else      {red, green, blue} = {pixel_data[15:12], pixel_data[10:7], pixel_data[4:1]};
`else
                {red, green, blue} = {pixel_data[15:12], pixel_data[10:7], pixel_data[4:1]};
`endif
            end else begin
                {red, green, blue} = BORDER_COLOR;
            end
        end
    end

endmodule

// File: tb/tb_vga_scaled_scanout.sv
// Bench for vga_scaled_scanout with a shrunk raster so several frames fit
// in a short run. A RAM model answers reads with random data; a reference
// model derives every expected output cycle from raster arithmetic.
module tb_vga_scaled_scanout;

  localparam int HA = 64, HFP = 4, HSY = 8, HBP = 4;
  localparam int VA = 24, VFP = 2, VSY = 2, VBP = 2;
  localparam int HSP = 0, VSP = 1;
  localparam int FBW = 20, FBH = 10, SC = 2, RDL = 2, AW = 9;
  localparam logic [11:0] BC = 12'h5A3;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;
  localparam int FRAME = HT * VT;
  localparam int LAT = RDL + 1;
  localparam int W = 26;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #20 clk = ~clk;

  logic [15:0]   pixel_data;
  logic          rd_en;
  logic [AW-1:0] read_addr;
  logic          hsync, vsync, active_video, frame_start;
  logic [3:0]    red, green, blue;

  vga_scaled_scanout #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .HS_POL(HSP), .VS_POL(VSP), .FB_W(FBW), .FB_H(FBH), .SCALE(SC),
    .RD_LATENCY(RDL), .ADDR_W(AW), .BORDER_COLOR(BC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef VGA_TESTPAT_EN
    .test_mode(1'b0),
`endif
    .pixel_data(pixel_data),
    .rd_en(rd_en),
    .read_addr(read_addr),
    .hsync(hsync),
    .vsync(vsync),
    .red(red),
    .green(green),
    .blue(blue),
    .active_video(active_video),
    .frame_start(frame_start)
  );

  // frame-buffer RAM model: data appears RDL cycles after the read strobe
  logic [15:0] mem [0:FBW*FBH-1];
  logic [15:0] ram_pipe [0:RDL-1];
  initial for (int i = 0; i < RDL; i++) ram_pipe[i] = 16'h0;
  always @(posedge clk) begin
    ram_pipe[0] <= rd_en ? mem[read_addr] : 16'($urandom);
    for (int i = 1; i < RDL; i++) ram_pipe[i] <= ram_pipe[i-1];
  end
  assign pixel_data = ram_pipe[RDL-1];

  // scoreboard
  int checks = 0;
  int errors = 0;
  int max_addr = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs;
  assign obs = {rd_en, read_addr, hsync, vsync, active_video, frame_start, red, green, blue};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic compare_word(input string pre, input logic [W-1:0] got, input logic [W-1:0] exp);
    check({pre, ".rd_en"}, 32'(got[25]), 32'(exp[25]));
    check({pre, ".addr"}, 32'(got[24:16]), 32'(exp[24:16]));
    check({pre, ".sync"}, 32'(got[15:14]), 32'(exp[15:14]));
    check({pre, ".active"}, 32'(got[13]), 32'(exp[13]));
    check({pre, ".frame_start"}, 32'(got[12]), 32'(exp[12]));
    check({pre, ".rgb"}, 32'(got[11:0]), 32'(exp[11:0]));
  endtask

  function automatic logic [W-1:0] reset_word();
    bit hp = (HSP != 0);
    bit vp = (VSP != 0);
    return {1'b0, 9'd0, ~hp, ~vp, 1'b0, 1'b0, 12'h000};
  endfunction

  // reference model: expected outputs n cycles after reset release
  function automatic logic [W-1:0] model(input int n);
    int p, h, v, a;
    bit pic, act, hs, vs, fs, rd;
    bit hp = (HSP != 0);
    bit vp = (VSP != 0);
    logic [15:0] d;
    logic [11:0] rgb;
    logic [W-1:0] r;
    r = reset_word();
    if (n >= 1) begin
      p = n - 1;
      h = p % HT;
      v = (p / HT) % VT;
      rd = (h < FBW * SC) && (v < FBH * SC);
      r[25] = rd;
      r[24:16] = rd ? 9'((v / SC) * FBW + h / SC) : 9'd0;
    end
    if (n >= LAT) begin
      p = n - LAT;
      h = p % HT;
      v = (p / HT) % VT;
      act = (h < HA) && (v < VA);
      pic = (h < FBW * SC) && (v < FBH * SC);
      hs = (h >= HA + HFP) && (h < HA + HFP + HSY);
      vs = (v >= VA + VFP) && (v < VA + VFP + VSY);
      fs = (h == 0) && (v == 0);
      a = (v / SC) * FBW + h / SC;
      rgb = 12'h000;
      if (act && pic) begin
        d = mem[a];
        rgb = {d[15:12], d[10:7], d[4:1]};
      end else if (act) begin
        rgb = BC;
      end
      r[15] = hs ? hp : ~hp;
      r[14] = vs ? vp : ~vp;
      r[13] = act;
      r[12] = fs;
      r[11:0] = rgb;
    end
    return r;
  endfunction

  task automatic fill_mem();
    for (int i = 0; i < FBW * FBH; i++) mem[i] = 16'($urandom);
  endtask

  // called right after rst_n is released at a falling edge
  task automatic run_seg(input int ncyc);
    logic [W-1:0] e;
    exp_q.delete();
    for (int n = 0; n < ncyc; n++) exp_q.push_back(model(n));
    for (int n = 0; n < ncyc; n++) begin
      if (n > 0) @(negedge clk);
      #1;
      e = exp_q.pop_front();
      compare_word("run", obs, e);
      if (rd_en && int'(read_addr) > max_addr) max_addr = int'(read_addr);
    end
  endtask

  initial begin
    fill_mem();
    repeat (3) @(negedge clk);
    #1;
    compare_word("rst_init", obs, reset_word());

    @(negedge clk);
    rst_n = 1'b1;
    run_seg(2 * FRAME + 11 * HT + 30);

    // asynchronous reset in the middle of the picture
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    compare_word("rst_async", obs, reset_word());
    fill_mem();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      compare_word("rst_hold", obs, reset_word());
    end

    @(negedge clk);
    rst_n = 1'b1;
    run_seg(FRAME + 2 * HT + 7);

    check("max_addr", 32'(max_addr), 32'(FBW * FBH - 1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
